day_of_yr_decode: RTL and testbench

DAY_OF_YR_DECODE -- requirements
Module: day_of_yr_decode

---
 rtl/day_of_yr_decode_if.sv | 20 ++
 rtl/day_of_yr_decode.sv | 69 ++++++
 tb/tb_day_of_yr_decode.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/day_of_yr_decode_if.sv
// day_of_yr_decode_if: request/result handshake bundle for the day-of-year decoder.
interface day_of_yr_decode_if;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] dayOfYear;
    logic       leapYear;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] month;
    logic [5:0] dayOfMonth;
    logic       error;
    modport master (
        output in_valid, dayOfYear, leapYear, out_ready,
        input  in_ready, out_valid, month, dayOfMonth, error
    );
    modport slave (
        input  in_valid, dayOfYear, leapYear, out_ready,
        output in_ready, out_valid, month, dayOfMonth, error
    );
endinterface

// File: rtl/day_of_yr_decode.sv
// day_of_yr_decode: converts an ordinal day into month/day, walking one month per cycle.
module day_of_yr_decode #(
    parameter bit LEAP_EN = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    day_of_yr_decode_if.slave   s_bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t     r_state, w_next;
    logic [8:0] r_rem, w_len;
    logic [3:0] r_cur_month, r_month;
    logic [5:0] r_dom;
    logic       r_leap_q, r_error, w_bad, w_hit;
    always_comb begin
        w_len = r_cur_month == 4'd2 ? (r_leap_q ? 9'd29 : 9'd28) :
                (r_cur_month == 4'd4 || r_cur_month == 4'd6 ||
                 r_cur_month == 4'd9 || r_cur_month == 4'd11) ? 9'd30 : 9'd31;
        // Range check only makes sense while rem still holds the raw request
        w_bad = r_cur_month == 4'd1 &&
                (r_rem == 9'd0 || r_rem > (r_leap_q ? 9'd366 : 9'd365));
        w_hit = r_rem <= w_len || r_cur_month == 4'd12;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = s_bus.in_valid ? CALC : IDLE;
            CALC:    w_next = (w_bad || w_hit) ? DONE : CALC;
            DONE:    w_next = s_bus.out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        s_bus.in_ready   = r_state == IDLE;
        s_bus.out_valid  = r_state == DONE;
        s_bus.month      = r_month;
        s_bus.dayOfMonth = r_dom;
        s_bus.error      = r_error;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_rem       <= '0;
            r_cur_month <= '0;
            r_leap_q    <= 1'b0;
            r_month     <= '0;
            r_dom       <= '0;
            r_error     <= 1'b0;
        end else if (r_state == IDLE && s_bus.in_valid) begin
            r_rem       <= s_bus.dayOfYear;
            r_leap_q    <= s_bus.leapYear & LEAP_EN;
            r_cur_month <= 4'd1;
        end else if (r_state == CALC) begin
            if (w_bad) begin
                r_month <= '0;
                r_dom   <= '0;
                r_error <= 1'b1;
            end else if (w_hit) begin
                r_month <= r_cur_month;
                r_dom   <= r_rem[5:0];
                r_error <= 1'b0;
            end else begin
                r_rem       <= r_rem - w_len;
                r_cur_month <= r_cur_month + 4'd1;
            end
        end
endmodule

// File: tb/tb_day_of_yr_decode.sv
// tb_day_of_yr_decode: directed vectors against both LEAP_EN settings.
module tb_day_of_yr_decode;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sel = 1'b0;
    logic       iv = 1'b0;
    logic [8:0] day = '0;
    logic       leap = 1'b0;
    logic       ordy = 1'b1;
    int         n_chk = 0;
    int         n_fail = 0;
    day_of_yr_decode_if b0 ();
    day_of_yr_decode_if b1 ();
    day_of_yr_decode #(.LEAP_EN(1'b1)) u_dut0 (.clk(clk), .reset_n(reset_n), .s_bus(b0.slave));
    day_of_yr_decode #(.LEAP_EN(1'b0)) u_dut1 (.clk(clk), .reset_n(reset_n), .s_bus(b1.slave));
    assign b0.in_valid  = iv & ~sel;
    assign b1.in_valid  = iv & sel;
    assign b0.dayOfYear = day;
    assign b1.dayOfYear = day;
    assign b0.leapYear  = leap;
    assign b1.leapYear  = leap;
    assign b0.out_ready = ordy;
    assign b1.out_ready = ordy;
    logic       ov, rdy, er;
    logic [3:0] mo;
    logic [5:0] dm;
    assign ov  = sel ? b1.out_valid  : b0.out_valid;
    assign rdy = sel ? b1.in_ready   : b0.in_ready;
    assign er  = sel ? b1.error      : b0.error;
    assign mo  = sel ? b1.month      : b0.month;
    assign dm  = sel ? b1.dayOfMonth : b0.dayOfMonth;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!rdy && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", {31'd0, rdy}, 1);
    endtask
    task automatic accept(input logic s, input logic [8:0] d, input logic l, input logic r);
        sel = s;
        wait_idle();
        day  = d;
        leap = l;
        ordy = r;
        iv   = 1'b1;
        @(posedge clk);
        #1 iv = 1'b0;
    endtask
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!ov && lat < 20);
    endtask
    task automatic decode(input string tag, input logic s, input logic [8:0] d, input logic l,
                          input int exp_m, input int exp_d, input int exp_e, input int exp_lat);
        int lat;
        accept(s, d, l, 1'b1);
        wait_valid(lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_month"}, {28'd0, mo}, exp_m);
        check({tag, "_dom"}, {26'd0, dm}, exp_d);
        check({tag, "_err"}, {31'd0, er}, exp_e);
    endtask
    initial begin
        int lat;
        #12;
        check("rst_rdy", {31'd0, b0.in_ready}, 1);
        check("rst_ov", {31'd0, b0.out_valid}, 0);
        check("rst_month", {28'd0, b0.month}, 0);
        check("rst_dom", {26'd0, b0.dayOfMonth}, 0);
        check("rst_err", {31'd0, b0.error}, 0);
        @(negedge clk) reset_n = 1'b1;
        decode("d1",      0, 9'd1,   0, 1, 1, 0, 1);
        decode("d60",     0, 9'd60,  0, 3, 1, 0, 3);
        decode("d60l",    0, 9'd60,  1, 2, 29, 0, 2);
        decode("d60noen", 1, 9'd60,  1, 3, 1, 0, 3);
        decode("d59",     0, 9'd59,  0, 2, 28, 0, 2);
        decode("d365",    0, 9'd365, 0, 12, 31, 0, 12);
        decode("d0",      0, 9'd0,   0, 0, 0, 1, 1);
        decode("d366l",   0, 9'd366, 1, 12, 31, 0, 12);
        decode("d366",    0, 9'd366, 0, 0, 0, 1, 1);
        decode("d335",    0, 9'd335, 0, 12, 1, 0, 12);
        decode("d511",    0, 9'd511, 1, 0, 0, 1, 1);
        decode("d367l",   0, 9'd367, 1, 0, 0, 1, 1);
        decode("d366noen",1, 9'd366, 1, 0, 0, 1, 1);
        // Back-pressure: result must hold while extra requests are ignored
        accept(0, 9'd32, 0, 1'b0);
        day = 9'd100;
        iv  = 1'b1;
        wait_valid(lat);
        check("bp_lat", lat, 2);
        for (int i = 0; i < 5; i++) begin
            check("bp_ov", {31'd0, ov}, 1);
            check("bp_month", {28'd0, mo}, 2);
            check("bp_dom", {26'd0, dm}, 1);
            check("bp_rdy", {31'd0, rdy}, 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        iv   = 1'b0;
        ordy = 1'b1;
        @(posedge clk);
        #1;
        check("bp_ov_drop", {31'd0, ov}, 0);
        check("bp_idle", {31'd0, rdy}, 1);
        @(posedge clk);
        #1;
        check("bp_no_queue", {31'd0, rdy}, 1);
        check("bp_hold_month", {28'd0, mo}, 2);
        // Abort mid-calculation
        accept(0, 9'd300, 0, 1'b1);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("ar_ov", {31'd0, ov}, 0);
        check("ar_rdy", {31'd0, rdy}, 1);
        check("ar_month", {28'd0, mo}, 0);
        check("ar_dom", {26'd0, dm}, 0);
        check("ar_err", {31'd0, er}, 0);
        repeat (12) begin
            @(posedge clk);
            #1;
            check("ar_no_ov", {31'd0, ov}, 0);
        end
        @(negedge clk) reset_n = 1'b1;
        decode("d300", 0, 9'd300, 0, 10, 27, 0, 10);
        decode("d1b",  0, 9'd1,   0, 1, 1, 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
